seq_checker: RTL and testbench
==============================

Name: seq_checker

Overview:
- Downstream consumer of the sequence generator: latches the generated sequence on `new_seq` and waits for the display phase to end.
- Then accepts player digit entries one per enter press, compares each against the stored sequence most-significant digit first, and reports pass/fail.
- Keeps a streak score of consecutive passed rounds for the score display and top-level game FSM.

Parameters:
- SEQ_DIGITS, 5, number of digits per sequence
- DIGIT_W, 4, bits per digit; SEQ_DIGITS*DIGIT_W must equal the sequence width (20)
- TIMEOUT_CYCLES, 250000000, idle cycles allowed between entries before fail (5 s at 50 MHz)
- SCORE_W, 8, streak counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- new_seq  in  1  one-cycle pulse: seq is valid, start a round
- seq  in  SEQ_DIGITS*DIGIT_W  generated sequence, digit 0 = bits [19:16]
- display  in  1  high while the sequence is shown to the player
- b_enter  in  1  one-cycle pulse (debounced and edge-detected upstream): digit_in is valid
- digit_in  in  DIGIT_W  player digit
- entry_active  out  1  high in ENTRY state
- entry_idx  out  3  digits accepted so far this round (0..SEQ_DIGITS-1)
- result_valid  out  1  one-cycle pulse: round finished
- result_pass  out  1  valid with result_valid: 1 = all digits matched
- timed_out  out  1  valid with result_valid: 1 = fail caused by timeout
- score  out  SCORE_W  consecutive passed rounds, saturating

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge):
  - state=IDLE
  - seq_reg=0, entry_idx=0, timer=0, score=0
  - entry_active=0, result_valid=0, result_pass=0, timed_out=0
  - rst overrides every other input, including mid-round.
- States: IDLE, WAIT_DISP, ENTRY, PASS, FAIL.
- IDLE:
  - new_seq=1 -> latch seq into seq_reg, entry_idx=0, go WAIT_DISP.
  - b_enter is ignored.
- WAIT_DISP:
  - Minimum one cycle.
  - On an edge where display=0 -> go ENTRY with timer=0.
  - b_enter is ignored.
- ENTRY, on b_enter=1, compare digit_in with seq_reg digit[entry_idx]:
  - Mismatch -> FAIL with timed_out=0.
  - Match and entry_idx==SEQ_DIGITS-1 -> PASS.
  - Match otherwise -> entry_idx+1, timer=0.
- ENTRY, without b_enter: timer increments; timer==TIMEOUT_CYCLES-1 -> FAIL with timed_out=1.
- b_enter and timeout on the same edge: b_enter wins and the press is evaluated.
- PASS (one cycle):
  - result_valid=1, result_pass=1.
  - score+1, saturating at all-ones.
  - Next state IDLE.
- FAIL (one cycle):
  - result_valid=1, result_pass=0.
  - score=0.
  - Next state IDLE.
- Result latency: the deciding b_enter is sampled at edge N; result_valid is high for exactly the cycle after edge N+1.
- result_pass and timed_out hold their values until the next result.
- new_seq in WAIT_DISP or ENTRY: abort the round with no result pulse, relatch seq, entry_idx=0, go WAIT_DISP; score unchanged.
- new_seq in the PASS/FAIL cycle: the result pulse is still emitted, seq is latched, next state WAIT_DISP.
- seq changing while new_seq=0 has no effect.
- entry_idx is held at its last value in PASS/FAIL and cleared on the next latch.

Decomposition:
- Shared package:
  - state enum (IDLE, WAIT_DISP, ENTRY, PASS, FAIL)
  - SEQ_W=20, DIGIT_W=4, SEQ_DIGITS=5
  - digit-select helper indexing seq_reg MSB-first
- Sub-module `entry_timer`:
  - inputs: clear, enable
  - output: expired
  - counter sized $clog2(TIMEOUT_CYCLES)
- Checker FSM, seq_reg and score stay in seq_checker.

Test Plan:
- Correct entry (TIMEOUT_CYCLES=16): new_seq with seq=20'h3A7F1, display high 4 cycles then low; press 3,A,7,F,1 -> result_valid one cycle after the 5th press, result_pass=1, timed_out=0, score=1.
- Wrong digit: same seq; press 3,A,6 -> FAIL on 3rd press, result_pass=0, timed_out=0, score=0, entry_idx=2 at the result.
- Timeout: enter ENTRY and press nothing -> after 16 idle cycles, result_valid with timed_out=1, result_pass=0; presses during WAIT_DISP (display=1) are ignored and entry_idx stays 0.
- Abort/relatch: two digits correct, then new_seq with seq=20'h00000 -> no result_valid, entry_idx=0, state WAIT_DISP; five 0 presses then pass.
- Streak and saturation: SCORE_W=2, four consecutive passes -> score 1,2,3,3; one fail -> 0.
- Reset mid-ENTRY: rst=1 for one cycle after 3 correct digits -> every output 0 on the next cycle and b_enter is ignored until a new new_seq.

Source files
------------

// File: rtl/seq_checker_pkg.sv
// Shared types, sizes and the MSB-first digit selector for the sequence checker.
// Digit 0 of a sequence lives in the top nibble.
package seq_checker_pkg;

   localparam int SEQ_DIGITS = 5;
   localparam int DIGIT_W    = 4;
   localparam int SEQ_W      = SEQ_DIGITS * DIGIT_W;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DISP,
      ENTRY,
      PASS,
      FAIL
   } state_t;

   function automatic logic [DIGIT_W-1:0] seq_digit(input logic [SEQ_W-1:0] s,
                                                    input logic [2:0]       idx);
      logic [DIGIT_W-1:0] d;
      d = '0;
      for (int i = 0; i < SEQ_DIGITS; i++) begin
         if (idx == i[2:0]) d = s[SEQ_W-1-i*DIGIT_W -: DIGIT_W];
      end
      return d;
   endfunction

endpackage

// File: rtl/seq_checker_entry_timer.sv
// Idle-time counter between player entries; expired flags the last allowed cycle.
// Clear has priority over enable so a press restarts the window on the same edge.
module entry_timer #(
   parameter int TIMEOUT_CYCLES = 250000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/seq_checker.sv
// Latches a generated sequence, checks the player's entries MSB digit first, reports pass/fail
// one cycle after the deciding press and keeps a saturating streak of passed rounds.
module seq_checker
   import seq_checker_pkg::*;
#(
   parameter int SEQ_DIGITS     = 5,
   parameter int DIGIT_W        = 4,
   parameter int TIMEOUT_CYCLES = 250000000,
   parameter int SCORE_W        = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          new_seq,
   input  logic [SEQ_DIGITS*DIGIT_W-1:0] seq,
   input  logic                          display,
   input  logic                          b_enter,
   input  logic [DIGIT_W-1:0]            digit_in,
   output logic                          entry_active,
   output logic [2:0]                    entry_idx,
   output logic                          result_valid,
   output logic                          result_pass,
   output logic                          timed_out,
   output logic [SCORE_W-1:0]            score
);

   localparam logic [2:0] LAST_IDX = 3'(SEQ_DIGITS - 1);

   state_t                        state;
   logic [SEQ_DIGITS*DIGIT_W-1:0] seq_reg;
   logic                          fail_timeout;
   logic                          expired;
   logic                          press_ok;

   entry_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  ((state != ENTRY) || b_enter),
      .enable ((state == ENTRY) && !b_enter),
      .expired(expired)
   );

   assign press_ok = (digit_in == seq_digit(seq_reg, entry_idx));

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         seq_reg      <= '0;
         entry_idx    <= '0;
         score        <= '0;
         entry_active <= 1'b0;
         result_valid <= 1'b0;
         result_pass  <= 1'b0;
         timed_out    <= 1'b0;
         fail_timeout <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         entry_active <= 1'b0;
         case (state)
            IDLE: ;
            WAIT_DISP: begin
               if (!display) begin
                  state        <= ENTRY;
                  entry_active <= 1'b1;
               end
            end
            ENTRY: begin
               if (b_enter) begin
                  if (!press_ok) begin
                     state        <= FAIL;
                     fail_timeout <= 1'b0;
                  end else if (entry_idx == LAST_IDX) begin
                     state <= PASS;
                  end else begin
                     entry_idx    <= entry_idx + 3'd1;
                     entry_active <= 1'b1;
                  end
               end else if (expired) begin
                  state        <= FAIL;
                  fail_timeout <= 1'b1;
               end else begin
                  entry_active <= 1'b1;
               end
            end
            PASS, FAIL: begin
               result_valid <= 1'b1;
               result_pass  <= (state == PASS);
               timed_out    <= (state == FAIL) && fail_timeout;
               if (state == FAIL) score <= '0;
               else if (score != '1) score <= score + SCORE_W'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // A new sequence restarts the round from any state; a pending result pulse still goes out.
         if (new_seq) begin
            seq_reg      <= seq;
            entry_idx    <= '0;
            entry_active <= 1'b0;
            state        <= WAIT_DISP;
         end
      end
   end

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with a short timeout and a 2-bit score to reach saturation.
module tb_seq_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        new_seq;
   logic [19:0] seq;
   logic        display;
   logic        b_enter;
   logic [3:0]  digit_in;
   logic        entry_active;
   logic [2:0]  entry_idx;
   logic        result_valid;
   logic        result_pass;
   logic        timed_out;
   logic [1:0]  score;

   int checks = 0;
   int errors = 0;

   seq_checker #(
      .SEQ_DIGITS    (5),
      .DIGIT_W       (4),
      .TIMEOUT_CYCLES(16),
      .SCORE_W       (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .new_seq     (new_seq),
      .seq         (seq),
      .display     (display),
      .b_enter     (b_enter),
      .digit_in    (digit_in),
      .entry_active(entry_active),
      .entry_idx   (entry_idx),
      .result_valid(result_valid),
      .result_pass (result_pass),
      .timed_out   (timed_out),
      .score       (score)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      b_enter  = 1'b1;
      digit_in = d;
      step();
      b_enter  = 1'b0;
   endtask

   task automatic start_round(input logic [19:0] s);
      new_seq = 1'b1;
      seq     = s;
      step();
      new_seq = 1'b0;
      display = 1'b1;
      repeat (4) step();
      check("wait_disp_inactive", 32'(entry_active), 0);
      display = 1'b0;
      step();
      check("entry_active", 32'(entry_active), 1);
   endtask

   task automatic enter_all(input logic [19:0] s);
      for (int i = 0; i < 5; i++) press(s[19-4*i -: 4]);
   endtask

   initial begin
      rst = 1'b1; new_seq = 1'b0; seq = '0; display = 1'b0; b_enter = 1'b0; digit_in = '0;
      step();
      step();
      check("rst_active",  32'(entry_active), 0);
      check("rst_idx",     32'(entry_idx), 0);
      check("rst_valid",   32'(result_valid), 0);
      check("rst_pass",    32'(result_pass), 0);
      check("rst_timeout", 32'(timed_out), 0);
      check("rst_score",   32'(score), 0);
      rst = 1'b0;
      press(4'h3);
      check("idle_press_idx", 32'(entry_idx), 0);

      // correct entry; seq changes after the latch must not matter
      start_round(20'h3A7F1);
      seq = 20'hFFFFF;
      press(4'h3); press(4'hA); press(4'h7); press(4'hF);
      check("ok_idx4", 32'(entry_idx), 4);
      press(4'h1);
      check("ok_no_early_valid", 32'(result_valid), 0);
      step();
      check("ok_valid", 32'(result_valid), 1);
      check("ok_pass",  32'(result_pass), 1);
      check("ok_to",    32'(timed_out), 0);
      check("ok_score", 32'(score), 1);
      step();
      check("ok_valid_pulse", 32'(result_valid), 0);
      check("ok_pass_hold",   32'(result_pass), 1);

      // wrong third digit
      start_round(20'h3A7F1);
      press(4'h3); press(4'hA); press(4'h6);
      step();
      check("bad_valid", 32'(result_valid), 1);
      check("bad_pass",  32'(result_pass), 0);
      check("bad_to",    32'(timed_out), 0);
      check("bad_score", 32'(score), 0);
      check("bad_idx",   32'(entry_idx), 2);

      // timeout, with presses ignored during display
      new_seq = 1'b1; seq = 20'h3A7F1;
      step();
      new_seq = 1'b0; display = 1'b1;
      press(4'h3); press(4'h3);
      check("disp_press_idx",    32'(entry_idx), 0);
      check("disp_press_active", 32'(entry_active), 0);
      display = 1'b0;
      step();
      repeat (15) step();
      check("to_still_entry", 32'(entry_active), 1);
      check("to_not_yet",     32'(result_valid), 0);
      step();
      check("to_left_entry",  32'(entry_active), 0);
      check("to_valid_late",  32'(result_valid), 0);
      step();
      check("to_valid", 32'(result_valid), 1);
      check("to_flag",  32'(timed_out), 1);
      check("to_pass",  32'(result_pass), 0);

      // press on the expiring edge wins over the timeout
      start_round(20'h3A7F1);
      repeat (15) step();
      press(4'h3);
      check("edge_press_idx",    32'(entry_idx), 1);
      check("edge_press_active", 32'(entry_active), 1);
      press(4'hA); press(4'h7); press(4'hF); press(4'h1);
      step();
      check("edge_valid", 32'(result_valid), 1);
      check("edge_pass",  32'(result_pass), 1);
      check("edge_to",    32'(timed_out), 0);
      check("edge_score", 32'(score), 1);

      // abort and relatch mid-round
      start_round(20'h3A7F1);
      press(4'h3); press(4'hA);
      new_seq = 1'b1; seq = 20'h00000;
      step();
      new_seq = 1'b0;
      check("abort_idx",    32'(entry_idx), 0);
      check("abort_active", 32'(entry_active), 0);
      check("abort_valid",  32'(result_valid), 0);
      check("abort_score",  32'(score), 1);
      step();
      check("abort_valid2", 32'(result_valid), 0);
      check("abort_entry",  32'(entry_active), 1);
      enter_all(20'h00000);
      step();
      check("abort_pass",  32'(result_pass), 1);
      check("abort_score2", 32'(score), 2);

      // reset in the middle of entry
      start_round(20'h3A7F1);
      press(4'h3); press(4'hA); press(4'h7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_active", 32'(entry_active), 0);
      check("mid_rst_idx",    32'(entry_idx), 0);
      check("mid_rst_valid",  32'(result_valid), 0);
      check("mid_rst_pass",   32'(result_pass), 0);
      check("mid_rst_to",     32'(timed_out), 0);
      check("mid_rst_score",  32'(score), 0);
      press(4'hF); press(4'h1);
      step();
      check("post_rst_idx",   32'(entry_idx), 0);
      check("post_rst_valid", 32'(result_valid), 0);

      // streak and saturation
      for (int k = 1; k <= 3; k++) begin
         start_round(20'h3A7F1);
         enter_all(20'h3A7F1);
         step();
         check("streak_valid", 32'(result_valid), 1);
         check("streak_score", 32'(score), 32'(k));
      end
      start_round(20'h3A7F1);
      enter_all(20'h3A7F1);
      new_seq = 1'b1; seq = 20'h12345;
      step();
      new_seq = 1'b0;
      check("sat_valid",  32'(result_valid), 1);
      check("sat_score",  32'(score), 3);
      check("sat_relatch_idx", 32'(entry_idx), 0);
      step();
      check("sat_direct_entry", 32'(entry_active), 1);
      press(4'h1);
      check("new_seq_digit0", 32'(entry_idx), 1);
      press(4'h9);
      step();
      check("streak_fail_valid", 32'(result_valid), 1);
      check("streak_fail_pass",  32'(result_pass), 0);
      check("streak_fail_score", 32'(score), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
